// File: rtl/marcador_juego_rtl_pkg.sv
// Shared game-scorer encodings: EST state codes and the default points-to-win.
// The match FSM and the benches import this same package.
package marcador_juego_rtl_pkg;

   localparam int unsigned PTS_WIN_DEF = 4;

   localparam logic [2:0] S_PLAY  = 3'd0;
   localparam logic [2:0] S_DEUCE = 3'd1;
   localparam logic [2:0] S_ADV1  = 3'd2;
   localparam logic [2:0] S_ADV2  = 3'd3;
   localparam logic [2:0] S_ERR   = 3'd4;

endpackage : marcador_juego_rtl_pkg

// File: rtl/marcador_juego_rtl_contador_puntos.sv
// Per-player point counter: clear, increment, or load the deuce value.
// Clear (and reset) win over load, which wins over increment.
module contador_puntos #(
   parameter int unsigned           CNT_W    = 3,
   parameter logic [CNT_W-1:0]      LOAD_VAL = '0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic             inc_i,
   input  logic             load_i,
   output logic [CNT_W-1:0] cnt_o
);

   logic [CNT_W-1:0] cnt_q;

   // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= LOAD_VAL;
      end else if (inc_i) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign cnt_o = cnt_q;

endmodule : contador_puntos

// File: rtl/marcador_juego_rtl.sv
// Tennis-style game scorer feeding J1G/J2G into the best-of-5 match FSM.
// Deuce/advantage FSM, registered one-cycle win pulses and a sticky double-strobe error.
module marcador_juego_rtl
   import marcador_juego_rtl_pkg::*;
#(
   parameter int unsigned PTS_WIN = PTS_WIN_DEF,
   parameter int unsigned CNT_W   = 3
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             P1P,
   input  logic             P2P,
   input  logic             Hab,
   output logic             J1G,
   output logic             J2G,
   output logic [CNT_W-1:0] PTS1,
   output logic [CNT_W-1:0] PTS2,
   output logic [2:0]       EST,
   output logic             ERR_PP
);

   localparam logic [CNT_W-1:0] DEUCE_C = CNT_W'(PTS_WIN - 1);
   localparam logic [CNT_W-1:0] LEAD_C  = CNT_W'(PTS_WIN - 2);

   logic [2:0] est_q, est_d;
   logic       j1g_q, j1g_d, j2g_q, j2g_d;
   logic       err_q, err_d;
   logic       clr, inc1, inc2, ld;
   logic       p1_ev, p2_ev, both_ev;

   assign p1_ev   = Hab & P1P & ~P2P;
   assign p2_ev   = Hab & P2P & ~P1P;
   assign both_ev = Hab & P1P & P2P;

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      est_d = est_q;
      err_d = err_q;
      j1g_d = 1'b0;
      j2g_d = 1'b0;
      clr   = 1'b0;
      inc1  = 1'b0;
      inc2  = 1'b0;
      ld    = 1'b0;
      case (est_q)
         S_PLAY, S_DEUCE, S_ADV1, S_ADV2: begin
            if (both_ev) begin
               est_d = S_ERR;
               err_d = 1'b1;
            end else if (p1_ev) begin
               case (est_q)
                  S_PLAY: begin
                     if (PTS1 == DEUCE_C && PTS2 <= LEAD_C) begin
                        j1g_d = 1'b1;
                        clr   = 1'b1;
                     end else begin
                        inc1 = 1'b1;
                        if (PTS1 == LEAD_C && PTS2 == DEUCE_C) est_d = S_DEUCE;
                     end
                  end
                  S_DEUCE: begin
                     inc1  = 1'b1;
                     est_d = S_ADV1;
                  end
                  S_ADV1: begin
                     j1g_d = 1'b1;
                     clr   = 1'b1;
                     est_d = S_PLAY;
                  end
                  default: begin
                     ld    = 1'b1;
                     est_d = S_DEUCE;
                  end
               endcase
            end else if (p2_ev) begin
               case (est_q)
                  S_PLAY: begin
                     if (PTS2 == DEUCE_C && PTS1 <= LEAD_C) begin
                        j2g_d = 1'b1;
                        clr   = 1'b1;
                     end else begin
                        inc2 = 1'b1;
                        if (PTS2 == LEAD_C && PTS1 == DEUCE_C) est_d = S_DEUCE;
                     end
                  end
                  S_DEUCE: begin
                     inc2  = 1'b1;
                     est_d = S_ADV2;
                  end
                  S_ADV2: begin
                     j2g_d = 1'b1;
                     clr   = 1'b1;
                     est_d = S_PLAY;
                  end
                  default: begin
                     ld    = 1'b1;
                     est_d = S_DEUCE;
                  end
               endcase
            end
         end
         S_ERR: ;
         default: begin
            est_d = S_PLAY;
            clr   = 1'b1;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         est_q <= S_PLAY;
         err_q <= 1'b0;
         j1g_q <= 1'b0;
         j2g_q <= 1'b0;
      end else begin
         est_q <= est_d;
         err_q <= err_d;
         j1g_q <= j1g_d;
         j2g_q <= j2g_d;
      end
   end

   // Returning from advantage reloads both counters to the deuce value.
   contador_puntos #(.CNT_W(CNT_W), .LOAD_VAL(DEUCE_C)) u_cnt1 (
      .clk_i  (Clk),
      .rst_i  (Reset),
      .clr_i  (clr),
      .inc_i  (inc1),
      .load_i (ld),
      .cnt_o  (PTS1)
   );

   contador_puntos #(.CNT_W(CNT_W), .LOAD_VAL(DEUCE_C)) u_cnt2 (
      .clk_i  (Clk),
      .rst_i  (Reset),
      .clr_i  (clr),
      .inc_i  (inc2),
      .load_i (ld),
      .cnt_o  (PTS2)
   );

   assign EST    = est_q;
   assign ERR_PP = err_q;
   assign J1G    = j1g_q;
   assign J2G    = j2g_q;

endmodule : marcador_juego_rtl

// File: doc/marcador_juego_rtl.md
Name: marcador_juego_rtl

Overview:
Point-level scorer for one game, placed directly upstream of the best-of-5 match FSM (Ganar_3_de_5_RTL). It counts single-cycle point strobes for two players using tennis-style rules: first to PTS_WIN points with a lead of 2, with deuce and advantage states. It emits a registered one-cycle game-won pulse (J1G/J2G) that drives the match FSM's J1G/J2G inputs directly. It flags simultaneous point strobes as an error.

Parameters:
PTS_WIN, 4, points needed to win a game (must be >= 2); deuce threshold is PTS_WIN-1.
CNT_W, 3, width of per-player point counters; must hold PTS_WIN.

Ports:
Clk  input  1  single system clock; all logic on rising edge.
Reset  input  1  synchronous, active-high reset.
P1P  input  1  point-won strobe, player 1; one cycle per point.
P2P  input  1  point-won strobe, player 2; one cycle per point.
Hab  input  1  enable; low = match finished or paused; strobes ignored.
J1G  output  1  registered game-won pulse, player 1; exactly one cycle.
J2G  output  1  registered game-won pulse, player 2; exactly one cycle.
PTS1  output  CNT_W  current point count, player 1.
PTS2  output  CNT_W  current point count, player 2.
EST  output  3  state code: 0 PLAY, 1 DEUCE, 2 ADV1, 3 ADV2, 4 ERR.
ERR_PP  output  1  sticky error: P1P and P2P were sampled high together.

Behaviour:
- Reset is synchronous and active-high. It is sampled on the Clk rising edge and has top priority, including over a pending pulse and over ERR.
- After reset: EST=0 (PLAY), PTS1=PTS2=0, J1G=J2G=0, ERR_PP=0.
- Strobes are sampled only when Hab=1. With Hab=0, state, counts and ERR_PP hold, and J1G/J2G are 0.
- P1P=P2P=1 with Hab=1: go to ERR at that edge and set ERR_PP=1. Counts freeze, no pulses are issued. ERR exits only via Reset.
- PLAY, single point for player X (other player Y):
  - X+1 == PTS_WIN and Y <= PTS_WIN-2: game won.
  - X+1 == PTS_WIN-1 and Y == PTS_WIN-1: enter DEUCE.
  - Otherwise: increment X's count.
- DEUCE: PTS1=PTS2=PTS_WIN-1. A P1 point goes to ADV1; a P2 point goes to ADV2.
- ADV1: PTS1=PTS_WIN, PTS2=PTS_WIN-1. A P1 point wins the game; a P2 point returns to DEUCE with counts back to PTS_WIN-1 each.
- ADV2: symmetric to ADV1.
- Game won at edge k:
  - J1G (or J2G) is high from edge k to edge k+1.
  - Counts clear to 0 and EST returns to PLAY at edge k.
- Latency from winning strobe to pulse is one cycle (registered outputs). A strobe in the pulse cycle is accepted normally as the first point of the next game.
- J1G and J2G are never high together. Each pulse is exactly one cycle; there are no glitches.
- Counts never exceed PTS_WIN, so there is no wrap-around. Unused EST codes 5–7 recover to PLAY with counts cleared.

Decomposition:
- Shared include/package: EST state codes (S_PLAY, S_DEUCE, S_ADV1, S_ADV2, S_ERR) and the PTS_WIN default. The match FSM and testbenches share the same encoding file.
- One natural sub-module: contador_puntos, a per-player counter with clear, increment and load-to-(PTS_WIN-1), instanced twice.
- The FSM, pulse register and error flag stay in the top.

Test Plan:
- Reset; P1P four times with idle cycles between -> PTS1 steps 1,2,3. On the 4th strobe: J1G=1 for one cycle, PTS1=PTS2=0, EST=0.
- Reset; three points each player, alternating -> EST=1, PTS1=PTS2=3. Then P1P -> EST=2. P2P -> EST=1. P2P -> EST=3. P2P -> J2G one-cycle pulse, EST=0.
- Reset; P1P on 4 consecutive cycles -> J1G exactly one cycle after the 4th edge. A P2P in that pulse cycle gives PTS2=1 and no J2G.
- Reset; P1P=P2P=1 for one cycle -> EST=4, ERR_PP=1. Further strobes produce no change and no pulses. Reset -> ERR_PP=0, EST=0.
- Hab=0; apply 6 P1P strobes -> PTS1 stays 0, J1G stays 0. Hab=1 -> counting resumes from 0.
- Reset asserted on the same edge as the winning point in ADV1 -> no J1G pulse; all outputs 0.
